// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the MIPS core memory path.
//   word_t      : 32-bit machine word.
//   ramstate_t  : status returned by the RAM model (FREE, BUSY, ACCESS, ERROR).
//   arb_state_t : mem_arbiter grant state (IDLE, IACC, DACC, HALTED).
//   streak_t    : width of the consecutive-data-grant counter, plus a
//                 saturating increment helper.
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IACC   = 2'd1,
        DACC   = 2'd2,
        HALTED = 2'd3
    } arb_state_t;

    // Wide enough for the largest allowed starvation limit (15).
    localparam int STREAK_W = 4;
    typedef logic [STREAK_W-1:0] streak_t;
    localparam streak_t STREAK_MAX = '1;

    function automatic streak_t streak_inc(input streak_t s);
        return (s == STREAK_MAX) ? s : s + streak_t'(1);
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// ----------------------------------------------------------------------------
// mem_arb_perf
//   Performance counters for mem_arbiter, present only when MEM_ARB_PERF_EN
//   is defined. All counters wrap at 2^32, clear on reset and freeze while
//   the arbiter is halted.
// Ports:
//   CLK        in   clock, rising edge
//   nRST       in   synchronous active-low reset
//   i_ihit     in   instruction hit strobe
//   i_dhit     in   data hit strobe
//   i_wait     in   arbiter is in an access state without ACCESS this cycle
//   i_halted   in   arbiter is in HALTED
//   o_icnt     out  number of ihits
//   o_dcnt     out  number of dhits
//   o_waitcnt  out  number of access cycles spent waiting on the RAM
// ----------------------------------------------------------------------------
module mem_arb_perf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  i_ihit,
    input  logic  i_dhit,
    input  logic  i_wait,
    input  logic  i_halted,
    output word_t o_icnt,
    output word_t o_dcnt,
    output word_t o_waitcnt
);

    word_t r_icnt;
    word_t r_dcnt;
    word_t r_waitcnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_icnt    <= '0;
            r_dcnt    <= '0;
            r_waitcnt <= '0;
        end else if (!i_halted) begin
            if (i_ihit) r_icnt    <= r_icnt + word_t'(1);
            if (i_dhit) r_dcnt    <= r_dcnt + word_t'(1);
            if (i_wait) r_waitcnt <= r_waitcnt + word_t'(1);
        end
    end

    assign o_icnt    = r_icnt;
    assign o_dcnt    = r_dcnt;
    assign o_waitcnt = r_waitcnt;

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Single-port RAM arbiter between instruction fetch and data access.
//   Data requests win, except when an instruction fetch has waited through
//   STARVE_LIMIT consecutive data grants. The grant is registered: a request
//   seen in one cycle drives the RAM the next cycle, and the hit strobe comes
//   in the cycle the RAM reports ACCESS.
//   Optional feature: define MEM_ARB_PERF_EN to add the icnt/dcnt/waitcnt
//   performance counter outputs.
// Ports:
//   CLK, nRST            clock; synchronous active-low reset
//   halt                 stop issuing new grants (in-flight access completes)
//   iREN, iaddr          instruction read request
//   dREN, dWEN, daddr,   data read / write request
//   dstore
//   ramstate, ramload    RAM status and read data
//   ramREN, ramWEN,      RAM request
//   ramaddr, ramstore
//   ihit, iload          instruction completion strobe and word
//   dhit, dload          data completion strobe and load data
//   icnt, dcnt, waitcnt  performance counters (MEM_ARB_PERF_EN only)
// ----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      halt,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  ramstate_t ramstate,
    input  word_t     ramload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload
`ifdef MEM_ARB_PERF_EN
    ,
    output word_t     icnt,
    output word_t     dcnt,
    output word_t     waitcnt
`endif
);

    localparam streak_t LIMIT = streak_t'(STARVE_LIMIT);

    arb_state_t r_state;
    streak_t    r_dstreak;
    word_t      r_addr;
    word_t      r_store;
    logic       r_wr;

    arb_state_t w_state_nxt;
    streak_t    w_dstreak_nxt;
    word_t      w_addr_nxt;
    word_t      w_store_nxt;
    logic       w_wr_nxt;
    logic       w_access;
    logic       w_dreq;
    logic       w_istarved;

    assign w_access   = (ramstate == ACCESS);
    assign w_dreq     = dREN | dWEN;
    // A pending fetch that has already sat through LIMIT data grants blocks data.
    assign w_istarved = iREN && (r_dstreak == LIMIT);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_dstreak_nxt = r_dstreak;
        w_addr_nxt    = r_addr;
        w_store_nxt   = r_store;
        w_wr_nxt      = r_wr;
        ramREN        = 1'b0;
        ramWEN        = 1'b0;
        ramaddr       = '0;
        ramstore      = '0;
        ihit          = 1'b0;
        dhit          = 1'b0;
        iload         = '0;
        dload         = '0;

        unique case (r_state)
            IDLE: begin
                if (w_dreq && !w_istarved) begin
                    w_state_nxt   = DACC;
                    w_addr_nxt    = daddr;
                    w_store_nxt   = dstore;
                    w_wr_nxt      = dWEN;
                    w_dstreak_nxt = streak_inc(r_dstreak);
                end else if (iREN && !halt) begin
                    w_state_nxt   = IACC;
                    w_addr_nxt    = iaddr;
                    w_store_nxt   = '0;
                    w_wr_nxt      = 1'b0;
                    w_dstreak_nxt = '0;
                end else if (halt) begin
                    w_state_nxt   = HALTED;
                end
                // The streak only measures data grants taken while a fetch waits.
                if (!iREN) w_dstreak_nxt = '0;
            end
            DACC: begin
                ramaddr  = r_addr;
                ramWEN   = r_wr;
                ramREN   = !r_wr;
                ramstore = r_wr ? r_store : '0;
                // BUSY, FREE and ERROR all hold the request; ERROR is a retry.
                if (w_access) begin
                    dhit        = 1'b1;
                    dload       = ramload;
                    w_state_nxt = IDLE;
                end
            end
            IACC: begin
                ramaddr = r_addr;
                ramREN  = 1'b1;
                if (w_access) begin
                    ihit        = 1'b1;
                    iload       = ramload;
                    w_state_nxt = IDLE;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_dstreak <= '0;
            r_addr    <= '0;
            r_store   <= '0;
            r_wr      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dstreak <= w_dstreak_nxt;
            r_addr    <= w_addr_nxt;
            r_store   <= w_store_nxt;
            r_wr      <= w_wr_nxt;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic w_wait;
    logic w_halted;

    assign w_wait   = ((r_state == IACC) || (r_state == DACC)) && !w_access;
    assign w_halted = (r_state == HALTED);

    mem_arb_perf u_perf (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_ihit    (ihit),
        .i_dhit    (dhit),
        .i_wait    (w_wait),
        .i_halted  (w_halted),
        .o_icnt    (icnt),
        .o_dcnt    (dcnt),
        .o_waitcnt (waitcnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (default build, STARVE_LIMIT = 4).
//   A transaction-level reference model tracks which requester owns the RAM
//   and predicts every output each cycle; directed steps add fixed-value
//   checks for the main scenarios, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      halt;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .halt     (halt),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ramstate (ramstate),
        .ramload  (ramload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ihit     (ihit),
        .dhit     (dhit),
        .iload    (iload),
        .dload    (dload)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the RAM port (0 none, 1 fetch, 2 data),
    // whether the arbiter is parked, and how many data grants a waiting
    // fetch has sat through.
    bit    m_valid  = 0;
    int    m_owner  = 0;
    bit    m_halted = 0;
    int    m_streak = 0;
    word_t m_addr   = '0;
    word_t m_store  = '0;
    bit    m_wr     = 0;

    // Outputs as seen at the last sample point.
    logic  snap_ramREN, snap_ramWEN, snap_ihit, snap_dhit;
    word_t snap_ramaddr, snap_ramstore, snap_iload, snap_dload;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        logic  e_ren, e_wen, e_ihit, e_dhit;
        word_t e_addr, e_store, e_iload, e_dload;
        e_ren = 0; e_wen = 0; e_ihit = 0; e_dhit = 0;
        e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
        if (m_owner == 1) begin
            e_ren  = 1;
            e_addr = m_addr;
            if (ramstate == ACCESS) begin
                e_ihit  = 1;
                e_iload = ramload;
            end
        end else if (m_owner == 2) begin
            e_ren   = !m_wr;
            e_wen   = m_wr;
            e_addr  = m_addr;
            e_store = m_wr ? m_store : '0;
            if (ramstate == ACCESS) begin
                e_dhit  = 1;
                e_dload = ramload;
            end
        end
        check("ramREN",   32'(ramREN),   32'(e_ren));
        check("ramWEN",   32'(ramWEN),   32'(e_wen));
        check("ramaddr",  ramaddr,       e_addr);
        check("ramstore", ramstore,      e_store);
        check("ihit",     32'(ihit),     32'(e_ihit));
        check("dhit",     32'(dhit),     32'(e_dhit));
        check("iload",    iload,         e_iload);
        check("dload",    dload,         e_dload);
    endtask

    task automatic model_update();
        bit want_d;
        bit starved;
        if (!nRST) begin
            m_valid  = 1;
            m_owner  = 0;
            m_halted = 0;
            m_streak = 0;
            m_addr   = '0;
            m_store  = '0;
            m_wr     = 0;
            return;
        end
        if (!m_valid) return;
        if (m_owner != 0) begin
            if (ramstate == ACCESS) m_owner = 0;
        end else if (!m_halted) begin
            want_d  = dREN || dWEN;
            starved = iREN && (m_streak == LIMIT);
            if (want_d && !starved) begin
                m_owner  = 2;
                m_addr   = daddr;
                m_store  = dstore;
                m_wr     = dWEN;
                m_streak = iREN ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
            end else if (iREN && !halt) begin
                m_owner  = 1;
                m_addr   = iaddr;
                m_wr     = 0;
                m_streak = 0;
            end else begin
                if (halt) m_halted = 1;
                if (!iREN) m_streak = 0;
            end
        end
    endtask

    // One clock cycle: sample and compare at the falling edge, advance the
    // model at the rising edge, then return 1 time unit later so the caller
    // can drive the next cycle's inputs.
    task automatic step();
        @(negedge CLK);
        snap_ramREN   = ramREN;
        snap_ramWEN   = ramWEN;
        snap_ramaddr  = ramaddr;
        snap_ramstore = ramstore;
        snap_ihit     = ihit;
        snap_dhit     = dhit;
        snap_iload    = iload;
        snap_dload    = dload;
        if (m_valid) compare_outputs();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    initial begin
        byte q[$];
        int  en_cnt;
        int  hit_cnt;
        int  hit_k;
        int  grants;

        nRST = 0; halt = 0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;

        // Reset then idle.
        step(); step();
        nRST = 1;
        step(); step();
        check("reset_state", 32'(dut.r_state), 32'(IDLE));
        check("reset_ramREN", 32'(snap_ramREN), 32'd0);

        // Single fetch with the RAM answering immediately.
        iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h2408000A;
        step();
        check("fetch_grant_lat", 32'(snap_ramREN), 32'd0);
        step();
        check("fetch_ramREN", 32'(snap_ramREN), 32'd1);
        check("fetch_ramaddr", snap_ramaddr, 32'h40);
        check("fetch_ihit", 32'(snap_ihit), 32'd1);
        check("fetch_iload", snap_iload, 32'h2408000A);
        iREN = 0;

        // Contention: write wins over a pending fetch.
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramload = 32'h1111_2222;
        step();
        step();
        check("cont_ramWEN", 32'(snap_ramWEN), 32'd1);
        check("cont_ramstore", snap_ramstore, 32'hDEADBEEF);
        check("cont_ramaddr", snap_ramaddr, 32'h100);
        check("cont_dhit", 32'(snap_dhit), 32'd1);
        check("cont_no_ihit", 32'(snap_ihit), 32'd0);
        dWEN = 0;
        step();
        step();
        check("cont_ihit", 32'(snap_ihit), 32'd1);
        check("cont_iaddr", snap_ramaddr, 32'h80);
        iREN = 0;
        step();

        // Starvation: both held continuously.
        iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
        for (int c = 0; c < 20; c++) begin
            ramload = $urandom;
            step();
            if (snap_dhit) q.push_back(byte'("D"));
            if (snap_ihit) q.push_back(byte'("I"));
        end
        check("starve_hits", 32'(q.size()), 32'd10);
        for (int k = 0; k < 10 && k < q.size(); k++)
            check("starve_order", 32'(q[k]), (k % 5 == 4) ? 32'(byte'("I")) : 32'(byte'("D")));
        iREN = 0; dREN = 0;
        step();

        // Wait and error retry on a data read.
        dREN = 1; daddr = 32'h400; ramstate = BUSY; ramload = 32'hCAFE_F00D;
        step();
        en_cnt = 0; hit_cnt = 0; hit_k = -1;
        for (int k = 0; k < 5; k++) begin
            ramstate = (k < 3) ? BUSY : ((k == 3) ? ERROR : ACCESS);
            step();
            en_cnt += int'(snap_ramREN);
            if (snap_dhit) begin
                hit_cnt++;
                hit_k = k;
            end
        end
        check("wait_enables", 32'(en_cnt), 32'd5);
        check("wait_hits", 32'(hit_cnt), 32'd1);
        check("wait_hit_cycle", 32'(hit_k), 32'd4);
        check("wait_dload", snap_dload, 32'hCAFE_F00D);
        dREN = 0;
        step();

        // Halt raised while a data access is in flight.
        dREN = 1; daddr = 32'h500; ramstate = BUSY;
        step();
        halt = 1;
        step();
        ramstate = ACCESS;
        step();
        check("halt_dhit", 32'(snap_dhit), 32'd1);
        dREN = 0;
        step();
        check("halt_state", 32'(dut.r_state), 32'(HALTED));
        iREN = 1; iaddr = 32'h600; halt = 0;
        grants = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            grants += int'(snap_ramREN) + int'(snap_ihit);
        end
        check("halt_no_grant", 32'(grants), 32'd0);
        check("halt_stays", 32'(dut.r_state), 32'(HALTED));
        nRST = 0;
        step();
        nRST = 1; iREN = 0;
        step();
        check("halt_reset_idle", 32'(dut.r_state), 32'(IDLE));

        // Reset in the middle of an access.
        dREN = 1; daddr = 32'h700; ramstate = BUSY;
        step();
        step();
        check("abort_before", 32'(snap_ramREN), 32'd1);
        nRST = 0;
        step();
        nRST = 1; dREN = 0; ramstate = ACCESS;
        step();
        check("abort_ramREN", 32'(snap_ramREN), 32'd0);
        check("abort_dhit", 32'(snap_dhit), 32'd0);
        check("abort_ramaddr", snap_ramaddr, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) begin
                iREN  = $urandom_range(1);
                iaddr = $urandom;
                case ($urandom_range(2))
                    0:       begin dREN = 0; dWEN = 0; end
                    1:       begin dREN = 1; dWEN = 0; end
                    default: begin dREN = 0; dWEN = 1; end
                endcase
                daddr  = $urandom;
                dstore = $urandom;
            end
            halt     = ($urandom_range(24) == 0);
            nRST     = ($urandom_range(19) != 0);
            ramstate = ramstate_t'($urandom_range(3));
            ramload  = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction fetch path and the data access path of the MIPS core. It grants one requester at a time onto the shared RAM port and returns the `ihit`/`dhit` strobes that the decode unit and pipeline consume for PC enable and stall decisions. Data requests have priority, and a starvation limit bounds instruction-fetch latency. The block sits between the cache/datapath request signals and the RAM model.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while an instruction request is pending. Range 1–15.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  synchronous reset, active-low, sampled on the rising edge of `CLK`.
- `halt`  in  1  halt from the decode unit; stops new grants.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  32 (`word_t`)  instruction address.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request. `dREN` and `dWEN` are never both high.
- `daddr`  in  32  data address.
- `dstore`  in  32  data write value.
- `ramstate`  in  `ramstate_t`  RAM status: FREE, BUSY, ACCESS, ERROR.
- `ramload`  in  32  RAM read data.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ihit`  out  1  instruction access complete; one-cycle strobe.
- `dhit`  out  1  data access complete; one-cycle strobe.
- `iload`  out  32  instruction word, valid while `ihit` is high.
- `dload`  out  32  load data, valid while `dhit` is high.

## Operation
States: IDLE, IACC, DACC, HALTED.

IDLE:
- If `dREN|dWEN` and not (`iREN` and `dstreak==STARVE_LIMIT`): latch `daddr`, `dstore` and the write flag, then go to DACC. Increment `dstreak`, saturating.
- Else if `iREN` and not `halt`: latch `iaddr`, go to IACC, clear `dstreak`.
- Else if `halt`: go to HALTED.
- Else stay in IDLE.
- If `iREN` is low in IDLE, clear `dstreak`.

DACC:
- Drive `ramaddr` from the latched address.
- For a write, drive `ramWEN` and `ramstore`; for a read, drive `ramREN`.
- On `ramstate==ACCESS`: `dhit=1` and `dload=ramload` in that same cycle, then go to IDLE.
- On BUSY or FREE: hold.
- On ERROR: hold and keep re-requesting (retry); no hit is issued.

IACC:
- Same as DACC, but always a read, and the completion strobes are `ihit` and `iload`.

HALTED:
- No RAM enables and no hits.
- Leave only on reset.
- A data access already in flight when `halt` rises completes first.

Outputs in IDLE/HALTED: `ramREN=ramWEN=0`, `ramaddr=0`, `ramstore=0`, `ihit=dhit=0`, `iload=dload=0`.

Requesters hold their request until the corresponding hit. A request that drops before its hit is ignored, because the latched access still completes; the resulting hit is discarded by the requester.

## Timing
- Reset: state=IDLE, `dstreak=0`, latched address/data=0, every output 0.
- Grant decision is registered. A request visible in cycle N drives RAM in cycle N+1. With the RAM returning ACCESS in N+1, the hit comes in N+1, so minimum latency is 1 cycle.
- After a hit there is one IDLE cycle before the next grant. Back-to-back accesses are therefore spaced at least 2 cycles apart.
- If both requests are present while `dstreak<STARVE_LIMIT`, data wins.
- Worst-case fetch wait is STARVE_LIMIT data accesses.
- Reset asserted mid-access aborts the access with no hit, and all outputs go to 0 on that edge.

## Configuration
- `MEM_ARB_PERF_EN` defined: adds outputs `icnt`, `dcnt`, `waitcnt`, each 32 bits.
  - `icnt` counts ihits; `dcnt` counts dhits.
  - `waitcnt` counts cycles in IACC/DACC without ACCESS.
  - All counters wrap at 2^32, clear on reset, and freeze in HALTED.
- `MEM_ARB_PERF_EN` undefined: the ports and counters are absent; functional behaviour is identical.

## Structure
- `arb_state_t` (IDLE, IACC, DACC, HALTED) goes in `cpu_types_pkg`, alongside the existing `ramstate_t` and `word_t`.
- `STARVE_LIMIT` stays a module parameter.
- Optional sub-module `mem_arb_perf`, holding the three counters, is instantiated only under `MEM_ARB_PERF_EN`.

## Test plan
- Reset then idle: `nRST=0` for 2 cycles, then all requests low → all outputs 0, state IDLE.
- Single fetch: `iREN=1`, `iaddr=0x40`, RAM ACCESS immediately with `ramload=0x2408000A` → `ramREN=1`, `ramaddr=0x40` the next cycle, with `ihit=1` and `iload=0x2408000A` in that same cycle.
- Contention: `iREN` and `dWEN` both high, `daddr=0x100`, `dstore=0xDEADBEEF` → data granted first (`ramWEN=1`, `ramstore=0xDEADBEEF`), `dhit`, then the instruction is granted.
- Starvation, with `STARVE_LIMIT=4`: `iREN` and `dREN` held continuously → exactly 4 `dhit`s, then 1 `ihit`, then the pattern repeats.
- Wait/error: `ramstate` = BUSY×3, ERROR×1, then ACCESS → RAM enables held for all 5 cycles and exactly one `dhit`, on the ACCESS cycle.
- Halt: `halt=1` during DACC → the `dhit` completes, the state goes to HALTED, and a later `iREN` gets no grant. `nRST=0` → back to IDLE.
